// File: rtl/palette_ram_arbiter.sv
// Arbitrates the single-port BG palette RAM between the CPU bus and PPU fetch.
// Narrow CPU writes become an atomic read-modify-write with GBA byte duplication.
module palette_ram_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W+1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    output logic [31:0]       ppu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = $clog2(CPU_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RMW_WR,
        CPU_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic [31:0]       merged;
    logic [ADDR_W-1:0] rmw_addr;

    logic              wait_max;
    logic              cpu_win;
    logic              cpu_wide;
    logic [ADDR_W-1:0] cpu_word;
    logic [15:0]       new_half;
    logic [31:0]       merged_d;
    logic              unused_ok;

    assign unused_ok = cpu_addr[0];
    assign wait_max  = (wait_cnt == CW'(CPU_MAX_WAIT));
    assign cpu_win   = (state == IDLE) & cpu_req & (~ppu_req | wait_max);
    assign cpu_wide  = cpu_size[1];
    assign cpu_word  = cpu_addr[ADDR_W+1:2];

    // Byte writes land in both bytes of the addressed halfword.
    assign new_half = cpu_size[0] ? cpu_wdata[15:0]
                                  : {cpu_wdata[7:0], cpu_wdata[7:0]};
    assign merged_d = cpu_addr[1] ? {new_half, ram_rdata[15:0]}
                                  : {ram_rdata[31:16], new_half};

    always_comb begin
        ppu_gnt   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rsta_n) begin
            unique case (state)
                IDLE: begin
                    if (cpu_win) begin
                        ram_addr = cpu_word;
                        if (cpu_we && cpu_wide) begin
                            ram_we    = 1'b1;
                            ram_wdata = cpu_wdata;
                        end
                    end else if (ppu_req) begin
                        ppu_gnt  = 1'b1;
                        ram_addr = ppu_addr;
                    end
                end
                RMW_WR: begin
                    ram_addr  = rmw_addr;
                    ram_we    = 1'b1;
                    ram_wdata = merged;
                end
                CPU_DONE: begin
                    if (ppu_req) begin
                        ppu_gnt  = 1'b1;
                        ram_addr = ppu_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            merged     <= '0;
            rmw_addr   <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            ppu_rvalid <= 1'b0;
            ppu_rdata  <= '0;
        end else begin
            cpu_ready  <= 1'b0;
            ppu_rvalid <= ppu_gnt;
            if (ppu_gnt) begin
                ppu_rdata <= ram_rdata;
            end
            unique case (state)
                IDLE: begin
                    if (cpu_win) begin
                        wait_cnt <= '0;
                        rmw_addr <= cpu_word;
                        if (!cpu_we) begin
                            cpu_rdata <= ram_rdata;
                            cpu_ready <= 1'b1;
                            state     <= CPU_DONE;
                        end else if (cpu_wide) begin
                            cpu_ready <= 1'b1;
                            state     <= CPU_DONE;
                        end else begin
                            merged <= merged_d;
                            state  <= RMW_WR;
                        end
                    end else if (cpu_req && ppu_gnt && !wait_max) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RMW_WR: begin
                    cpu_ready <= 1'b1;
                    state     <= CPU_DONE;
                end
                CPU_DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Bench for palette_ram_arbiter: directed scenarios plus randomized CPU/PPU
// traffic against a word-array model with GBA narrow-write semantics.
module tb_palette_ram_arbiter;

    localparam int AW = 8;
    localparam int MW = 4;

    logic          clka = 1'b0;
    logic          rsta_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_size;
    logic [AW+1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_ready;
    logic [31:0]   cpu_rdata;
    logic          ppu_req;
    logic [AW-1:0] ppu_addr;
    logic          ppu_gnt;
    logic          ppu_rvalid;
    logic [31:0]   ppu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    palette_ram_arbiter #(.ADDR_W(AW), .CPU_MAX_WAIT(MW)) dut (
        .clka(clka), .rsta_n(rsta_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt),
        .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clka = ~clka;

    // Behavioural RAM plus a preload port used while the arbiter is idle.
    logic [31:0]   mem [256];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clka) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;
    logic rand_ppu = 1'b0;
    logic mon_en = 1'b0;
    logic pend = 1'b0;
    logic [31:0] pend_d = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
            input logic [1:0] sz, input logic [9:0] a, input logic [31:0] wd);
        logic [31:0] r;
        logic [15:0] h;
        r = old;
        if (sz >= 2'd2) return wd;
        h = (sz == 2'd0) ? {wd[7:0], wd[7:0]} : wd[15:0];
        if (a[1]) r[31:16] = h;
        else r[15:0] = h;
        return r;
    endfunction

    task automatic tick();
        @(posedge clka);
        #1;
        if (rand_ppu) begin
            ppu_req  = ($urandom_range(0, 2) != 0);
            ppu_addr = AW'($urandom_range(0, 15));
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        pl_en = 1'b1;
        pl_addr = AW'(w);
        pl_data = d;
        tick();
        pl_en = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic cpu_op(input logic we, input logic [1:0] sz,
            input logic [9:0] a, input logic [31:0] wd,
            output logic [31:0] rd, output int lat);
        tick();
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_size = sz;
        cpu_addr = a;
        cpu_wdata = wd;
        lat = 0;
        do begin
            tick();
            #1;
            lat++;
        end while (cpu_ready !== 1'b1 && lat < 40);
        rd = cpu_rdata;
        chk("cpu_done", 32'(cpu_ready), 32'd1);
        cpu_req = 1'b0;
        if (we) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], sz, a, wd);
    endtask

    // PPU read returns the RAM word seen in its grant cycle; no write in a grant.
    always @(negedge clka) begin
        if (mon_en) begin
            chk("we_with_gnt", 32'(ram_we & ppu_gnt), 32'd0);
            if (pend) begin
                chk("ppu_rvalid", 32'(ppu_rvalid), 32'd1);
                chk("ppu_rdata", ppu_rdata, pend_d);
            end
            pend   <= ppu_gnt;
            pend_d <= mem[ppu_addr];
        end else begin
            pend <= 1'b0;
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        int lat;
        logic we;
        logic [1:0] sz;
        logic [9:0] a;
        logic [31:0] wd;

        rsta_n = 1'b0;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_size = 2'd2;
        cpu_addr = 10'h3c;
        cpu_wdata = 32'hffff_ffff;
        ppu_req = 1'b1;
        ppu_addr = 8'h07;
        repeat (2) @(posedge clka);
        #1;
        chk("rst_gnt", 32'(ppu_gnt), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_rvalid", 32'(ppu_rvalid), 32'd0);
        chk("rst_prdata", ppu_rdata, 32'd0);
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        rsta_n = 1'b1;

        // PPU streaming reads
        for (int i = 0; i < 4; i++) preload(i, 32'h1000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            tick();
            ppu_req = (i < 4);
            ppu_addr = AW'(i);
            #1;
            if (i < 4) chk("t1_gnt", 32'(ppu_gnt), 32'd1);
            if (i > 0) begin
                chk("t1_rvalid", 32'(ppu_rvalid), 32'd1);
                chk("t1_rdata", ppu_rdata, 32'h1000 + 32'(i - 1));
            end
        end
        ppu_req = 1'b0;
        tick();
        chk("t1_rvalid_off", 32'(ppu_rvalid), 32'd0);

        // Byte write timing
        preload(0, 32'h1122_3344);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_size = 2'd0;
        cpu_addr = 10'h003;
        cpu_wdata = 32'h0000_005a;
        #1;
        chk("t2_we_T", 32'(ram_we), 32'd0);
        tick();
        chk("t2_we_T1", 32'(ram_we), 32'd1);
        chk("t2_wdata", ram_wdata, 32'h5a5a_3344);
        chk("t2_ready_T1", 32'(cpu_ready), 32'd0);
        tick();
        chk("t2_ready_T2", 32'(cpu_ready), 32'd1);
        cpu_req = 1'b0;
        chk("t2_mem", mem[0], 32'h5a5a_3344);

        // Half write then read back
        preload(0, 32'h1122_3344);
        cpu_op(1'b1, 2'd1, 10'h001, 32'h0000_beef, rd, lat);
        chk("t3_lat_w", 32'(lat), 32'd2);
        chk("t3_mem", mem[0], 32'h1122_beef);
        cpu_op(1'b0, 2'd2, 10'h000, 32'h0, rd, lat);
        chk("t3_lat_r", 32'(lat), 32'd1);
        chk("t3_rdata", rd, 32'h1122_beef);

        // CPU starvation bound with PPU stuck on
        preload(1, 32'hcafe_f00d);
        ppu_req = 1'b1;
        ppu_addr = 8'h05;
        cpu_op(1'b0, 2'd2, 10'h004, 32'h0, rd, lat);
        chk("t4_lat", 32'(lat), 32'(MW + 1));
        chk("t4_rdata", rd, 32'hcafe_f00d);
        cpu_op(1'b0, 2'd3, 10'h006, 32'h0, rd, lat);
        chk("t4_lat2", 32'(lat), 32'(MW + 1));
        ppu_req = 1'b0;

        // RMW atomic against PPU
        preload(2, 32'haabb_ccdd);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_size = 2'd0;
        cpu_addr = 10'h009;
        cpu_wdata = 32'h0000_00c3;
        tick();
        ppu_req = 1'b1;
        ppu_addr = 8'h02;
        #1;
        chk("t5_gnt_rmw", 32'(ppu_gnt), 32'd0);
        chk("t5_we_rmw", 32'(ram_we), 32'd1);
        tick();
        chk("t5_ready", 32'(cpu_ready), 32'd1);
        chk("t5_gnt_done", 32'(ppu_gnt), 32'd1);
        cpu_req = 1'b0;
        tick();
        ppu_req = 1'b0;
        chk("t5_rvalid", 32'(ppu_rvalid), 32'd1);
        chk("t5_rdata", ppu_rdata, 32'haabb_c3c3);

        // Reset during the RMW write cycle
        preload(3, 32'h0102_0304);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_size = 2'd0;
        cpu_addr = 10'h00c;
        cpu_wdata = 32'h0000_0077;
        tick();
        rsta_n = 1'b0;
        #1;
        chk("t6_we", 32'(ram_we), 32'd0);
        chk("t6_addr", 32'(ram_addr), 32'd0);
        chk("t6_rdata", cpu_rdata, 32'd0);
        chk("t6_prdata", ppu_rdata, 32'd0);
        chk("t6_ready", 32'(cpu_ready), 32'd0);
        cpu_req = 1'b0;
        tick();
        tick();
        rsta_n = 1'b1;
        chk("t6_mem", mem[3], 32'h0102_0304);
        cpu_op(1'b0, 2'd2, 10'h00c, 32'h0, rd, lat);
        chk("t6_lat", 32'(lat), 32'd1);
        chk("t6_read", rd, 32'h0102_0304);

        // Randomized traffic
        for (int w = 0; w < 16; w++) preload(w, $urandom);
        tick();
        mon_en = 1'b1;
        rand_ppu = 1'b1;
        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = 10'($urandom_range(0, 63));
            wd = $urandom;
            exp = ref_mem[a[9:2]];
            cpu_op(we, sz, a, wd, rd, lat);
            checks++;
            assert (lat <= MW + 2) else begin
                errors++;
                $error("FAIL rnd_lat: observed %0d expected <= %0d", lat, MW + 2);
            end
            if (we) chk("rnd_mem", mem[a[9:2]], ref_mem[a[9:2]]);
            else chk("rnd_read", rd, exp);
        end
        rand_ppu = 1'b0;
        ppu_req = 1'b0;
        tick();
        tick();
        tick();
        mon_en = 1'b0;
        for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_mem[w]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
